decode_execute_stage: RTL and testbench

Decode→Execute pipeline register of the ARM-subset pipelined core, sitting directly downstream of the register file. Captures both read operands, immediate, destination and control bundle each cycle. Corrects operands for the same-cycle writeback write, which the register file only makes visible one cycle later. Detects load-use hazards, stalls decode and injects a bubble into Execute, with a saturating bubble counter for performance monitoring.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/operand_bypass.sv | 28 ++
 rtl/decode_execute_stage.sv | 168 ++++++++++++++++
 tb/tb_decode_execute_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// +-------------------------------------------------------------------------+
// | pipeline_pkg : control-bundle layout and register constants shared by   |
// |                the ARM-subset pipeline stages.  Revision: 1.0           |
// +-------------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  localparam int CTRL_W     = 12;
  localparam int CTRL_REGWR = 0;
  localparam int CTRL_LOAD  = 1;
  localparam int CTRL_USE2  = 2;

  localparam logic [3:0] REG_PC = 4'd15;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

`default_nettype wire

// File: rtl/operand_bypass.sv
// +-------------------------------------------------------------------------+
// | operand_bypass : substitutes same-cycle writeback data for a register-  |
// |                  file read operand (r15 excluded).  Revision: 1.0       |
// +-------------------------------------------------------------------------+
`default_nettype none

module operand_bypass #(
  parameter int DATA_W = 32
) (
  input  logic              w_we,
  input  logic [3:0]        w_wa,
  input  logic [DATA_W-1:0] w_wd,
  input  logic [3:0]        ra,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] op
);

  import pipeline_pkg::*;

  logic hit;

  // r15 reads carry PC+8 from the register file and must never be replaced
  assign hit = w_we && (w_wa == ra) && (ra != REG_PC);
  assign op  = hit ? w_wd : rd;

endmodule

`default_nettype wire

// File: rtl/decode_execute_stage.sv
// +-------------------------------------------------------------------------+
// | decode_execute_stage : D->E pipeline register with writeback bypass,    |
// |   load-use stall/bubble and saturating bubble counter.                  |
// |   Optional feature macro: DEX_WB_BYPASS_EN.  Revision: 1.0              |
// +-------------------------------------------------------------------------+
`default_nettype none

module decode_execute_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = pipeline_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [3:0]        d_ra1,
  input  logic [3:0]        d_ra2,
  input  logic [3:0]        d_wa,
  input  logic [DATA_W-1:0] d_rd1,
  input  logic [DATA_W-1:0] d_rd2,
  input  logic [DATA_W-1:0] d_imm,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              w_we,
  input  logic [3:0]        w_wa,
  input  logic [DATA_W-1:0] w_wd,
  input  logic              hold_e,
  input  logic              flush_e,
  output logic              stall_d,
  output logic              e_valid,
  output logic [3:0]        e_ra1,
  output logic [3:0]        e_ra2,
  output logic [3:0]        e_wa,
  output logic [DATA_W-1:0] e_op1,
  output logic [DATA_W-1:0] e_op2,
  output logic [DATA_W-1:0] e_imm,
  output logic [CTRL_W-1:0] e_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  import pipeline_pkg::CTRL_LOAD;
  import pipeline_pkg::CTRL_REGWR;
  import pipeline_pkg::CTRL_USE2;
  import pipeline_pkg::REG_PC;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              e_valid_q, e_valid_d;
  logic [3:0]        e_ra1_q, e_ra1_d;
  logic [3:0]        e_ra2_q, e_ra2_d;
  logic [3:0]        e_wa_q, e_wa_d;
  logic [DATA_W-1:0] e_op1_q, e_op1_d;
  logic [DATA_W-1:0] e_op2_q, e_op2_d;
  logic [DATA_W-1:0] e_imm_q, e_imm_d;
  logic [CTRL_W-1:0] e_ctrl_q, e_ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic [DATA_W-1:0] op1_byp;
  logic [DATA_W-1:0] op2_byp;

`ifdef DEX_WB_BYPASS_EN
  operand_bypass #(.DATA_W(DATA_W)) u_byp_op1 (
    .w_we (w_we),
    .w_wa (w_wa),
    .w_wd (w_wd),
    .ra   (d_ra1),
    .rd   (d_rd1),
    .op   (op1_byp)
  );

  operand_bypass #(.DATA_W(DATA_W)) u_byp_op2 (
    .w_we (w_we),
    .w_wa (w_wa),
    .w_wd (w_wd),
    .ra   (d_ra2),
    .rd   (d_rd2),
    .op   (op2_byp)
  );
`else
  logic unused_wb;

  assign op1_byp   = d_rd1;
  assign op2_byp   = d_rd2;
  assign unused_wb = ^{w_we, w_wa, w_wd};
`endif

  logic e_load_wr;
  logic src_match;
  logic hazard;

  // Built only from registered E state and decode indices, never from d_rd*
  assign e_load_wr = e_valid_q && e_ctrl_q[CTRL_LOAD] && e_ctrl_q[CTRL_REGWR]
                     && (e_wa_q != REG_PC);
  assign src_match = (e_wa_q == d_ra1) || (d_ctrl[CTRL_USE2] && (e_wa_q == d_ra2));
  assign hazard    = e_load_wr && d_valid && src_match;
  assign stall_d   = reset && !flush_e && (hold_e || hazard);

  always_comb begin
    e_valid_d    = e_valid_q;
    e_ra1_d      = e_ra1_q;
    e_ra2_d      = e_ra2_q;
    e_wa_d       = e_wa_q;
    e_op1_d      = e_op1_q;
    e_op2_d      = e_op2_q;
    e_imm_d      = e_imm_q;
    e_ctrl_d     = e_ctrl_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush_e) begin
      e_valid_d = 1'b0;
      e_ctrl_d  = '0;
    end else if (hold_e) begin
      e_valid_d = e_valid_q;
    end else if (hazard) begin
      // Bubble clears e_valid, so the hazard cannot persist past one cycle
      e_valid_d = 1'b0;
      e_ctrl_d  = '0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + C_CNT_ONE;
      end
    end else begin
      e_valid_d = d_valid;
      e_ra1_d   = d_ra1;
      e_ra2_d   = d_ra2;
      e_wa_d    = d_wa;
      e_op1_d   = op1_byp;
      e_op2_d   = op2_byp;
      e_imm_d   = d_imm;
      e_ctrl_d  = d_valid ? d_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid_q    <= 1'b0;
      e_ra1_q      <= '0;
      e_ra2_q      <= '0;
      e_wa_q       <= '0;
      e_op1_q      <= '0;
      e_op2_q      <= '0;
      e_imm_q      <= '0;
      e_ctrl_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      e_valid_q    <= e_valid_d;
      e_ra1_q      <= e_ra1_d;
      e_ra2_q      <= e_ra2_d;
      e_wa_q       <= e_wa_d;
      e_op1_q      <= e_op1_d;
      e_op2_q      <= e_op2_d;
      e_imm_q      <= e_imm_d;
      e_ctrl_q     <= e_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign e_valid    = e_valid_q;
  assign e_ra1      = e_ra1_q;
  assign e_ra2      = e_ra2_q;
  assign e_wa       = e_wa_q;
  assign e_op1      = e_op1_q;
  assign e_op2      = e_op2_q;
  assign e_imm      = e_imm_q;
  assign e_ctrl     = e_ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_execute_stage.sv
// +-------------------------------------------------------------------------+
// | tb_decode_execute_stage : directed bench with a behavioural model of    |
// |   the D->E register compared every cycle.  Revision: 1.0                |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_decode_execute_stage;

  import pipeline_pkg::*;

  // Narrow counter so saturation is reachable in a short run
  localparam int TB_CNT_W = 10;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  localparam logic [11:0] C_ALU   = 12'(1 << CTRL_REGWR);
  localparam logic [11:0] C_LOAD  = 12'((1 << CTRL_REGWR) | (1 << CTRL_LOAD));
  localparam logic [11:0] C_USE2R = 12'((1 << CTRL_REGWR) | (1 << CTRL_USE2));

`ifdef DEX_WB_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'hAA;
`else
  localparam logic [31:0] BYP_EXP = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        d_valid = 1'b0;
  logic [3:0]  d_ra1 = '0, d_ra2 = '0, d_wa = '0;
  logic [31:0] d_rd1 = '0, d_rd2 = '0, d_imm = '0;
  logic [11:0] d_ctrl = '0;
  logic        w_we = 1'b0;
  logic [3:0]  w_wa = '0;
  logic [31:0] w_wd = '0;
  logic        hold_e = 1'b0, flush_e = 1'b0;

  logic                stall_d, e_valid;
  logic [3:0]          e_ra1, e_ra2, e_wa;
  logic [31:0]         e_op1, e_op2, e_imm;
  logic [11:0]         e_ctrl;
  logic [TB_CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_execute_stage #(.DATA_W(32), .CTRL_W(12), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_ra1(d_ra1), .d_ra2(d_ra2), .d_wa(d_wa),
    .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm), .d_ctrl(d_ctrl),
    .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd),
    .hold_e(hold_e), .flush_e(flush_e), .stall_d(stall_d),
    .e_valid(e_valid), .e_ra1(e_ra1), .e_ra2(e_ra2), .e_wa(e_wa),
    .e_op1(e_op1), .e_op2(e_op2), .e_imm(e_imm), .e_ctrl(e_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [3:0]  m_ra1 = '0, m_ra2 = '0, m_wa = '0;
  logic [31:0] m_op1 = '0, m_op2 = '0, m_imm = '0;
  logic [11:0] m_ctrl = '0;
  int          m_cnt = 0;

  function automatic logic m_hazard();
    logic reads_dest;
    reads_dest = (m_wa == d_ra1) || (d_ctrl[CTRL_USE2] && (m_wa == d_ra2));
    return m_valid && m_ctrl[CTRL_LOAD] && m_ctrl[CTRL_REGWR] && (m_wa != 4'd15)
           && d_valid && reads_dest;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [3:0] ra, input logic [31:0] rd);
`ifdef DEX_WB_BYPASS_EN
    if (w_we && (w_wa == ra) && (ra != 4'd15)) return w_wd;
`endif
    return rd;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid <= 1'b0; m_ctrl <= '0; m_cnt <= 0;
      m_ra1 <= '0; m_ra2 <= '0; m_wa <= '0;
      m_op1 <= '0; m_op2 <= '0; m_imm <= '0;
    end else if (flush_e) begin
      m_valid <= 1'b0; m_ctrl <= '0;
    end else if (hold_e) begin
      m_valid <= m_valid;
    end else if (m_hazard()) begin
      m_valid <= 1'b0; m_ctrl <= '0;
      m_cnt   <= (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else begin
      m_valid <= d_valid;
      m_ctrl  <= d_valid ? d_ctrl : 12'h0;
      m_ra1 <= d_ra1; m_ra2 <= d_ra2; m_wa <= d_wa;
      m_op1 <= m_fwd(d_ra1, d_rd1);
      m_op2 <= m_fwd(d_ra2, d_rd2);
      m_imm <= d_imm;
    end
  end

  // Compare on the falling edge: registers settled, inputs stable
  always @(negedge clk) begin
    check("stall_d", stall_d, reset && !flush_e && (hold_e || m_hazard()));
    check("e_valid", e_valid, m_valid);
    check("e_ctrl", e_ctrl, m_ctrl);
    check("bubble_cnt", bubble_cnt, m_cnt);
    if (m_valid || !reset) begin
      check("e_ra1", e_ra1, m_ra1);
      check("e_ra2", e_ra2, m_ra2);
      check("e_wa", e_wa, m_wa);
      check("e_op1", e_op1, m_op1);
      check("e_op2", e_op2, m_op2);
      check("e_imm", e_imm, m_imm);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic v, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic [3:0] wa, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [11:0] ctrl);
    d_valid = v; d_ra1 = ra1; d_ra2 = ra2; d_wa = wa;
    d_rd1 = rd1; d_rd2 = rd2; d_imm = imm; d_ctrl = ctrl;
  endtask

  initial begin
    hold_e = 1'b1;
    repeat (2) step();
    check("rst_e_valid", e_valid, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    check("rst_e_op1", e_op1, 0);
    check("rst_stall_d", stall_d, 0);
    hold_e = 1'b0;
    reset  = 1'b1;

    // plain capture
    set_d(1, 4'd2, 4'd0, 4'd1, 32'h11, 32'h0, 32'h4, C_ALU);
    step();
    check("cap_e_op1", e_op1, 32'h11);
    check("cap_e_imm", e_imm, 32'h4);
    check("cap_e_valid", e_valid, 1);

    // writeback bypass, then r15 exclusion
    w_we = 1'b1; w_wa = 4'd3; w_wd = 32'hAA;
    set_d(1, 4'd0, 4'd3, 4'd1, 32'h0, 32'h0, 32'h0, C_USE2R);
    step();
    check("byp_e_op2", e_op2, BYP_EXP);
    w_wa = 4'd15;
    set_d(1, 4'd0, 4'd15, 4'd1, 32'h0, 32'h1234, 32'h0, C_USE2R);
    step();
    check("byp_pc_e_op2", e_op2, 32'h1234);
    w_we = 1'b0;

    // load-use on operand 1
    set_d(1, 4'd0, 4'd0, 4'd5, 32'h0, 32'h0, 32'h0, C_LOAD);
    step();
    set_d(1, 4'd5, 4'd0, 4'd6, 32'h55, 32'h0, 32'h0, C_ALU);
    #1 check("lu_stall", stall_d, 1);
    step();
    check("lu_bubble_valid", e_valid, 0);
    check("lu_cnt", bubble_cnt, 1);
    #1 check("lu_stall_drop", stall_d, 0);
    step();
    check("lu_cap_valid", e_valid, 1);
    check("lu_cap_op1", e_op1, 32'h55);
    check("lu_cap_wa", e_wa, 6);

    // operand 2 only counts when USE2 is set
    set_d(1, 4'd0, 4'd0, 4'd7, 32'h0, 32'h0, 32'h0, C_LOAD);
    step();
    set_d(1, 4'd0, 4'd7, 4'd8, 32'h0, 32'h77, 32'h0, C_ALU);
    #1 check("nouse2_stall", stall_d, 0);
    set_d(1, 4'd0, 4'd7, 4'd8, 32'h0, 32'h77, 32'h0, C_USE2R);
    #1 check("use2_stall", stall_d, 1);
    step();
    check("use2_cnt", bubble_cnt, 2);
    step();
    check("use2_cap_op2", e_op2, 32'h77);

    // load into r15 never stalls
    set_d(1, 4'd0, 4'd0, 4'd15, 32'h0, 32'h0, 32'h0, C_LOAD);
    step();
    set_d(1, 4'd15, 4'd0, 4'd9, 32'h0, 32'h0, 32'h0, C_ALU);
    #1 check("pc_load_stall", stall_d, 0);
    step();

    // flush beats a coincident hazard
    set_d(1, 4'd0, 4'd0, 4'd5, 32'h0, 32'h0, 32'h0, C_LOAD);
    step();
    set_d(1, 4'd5, 4'd0, 4'd6, 32'h66, 32'h0, 32'h0, C_ALU);
    flush_e = 1'b1;
    #1 check("fl_stall", stall_d, 0);
    step();
    check("fl_valid", e_valid, 0);
    check("fl_ctrl", e_ctrl, 0);
    check("fl_cnt", bubble_cnt, 2);
    flush_e = 1'b0;
    #1 check("fl_stall_after", stall_d, 0);
    step();
    check("fl_cap_op1", e_op1, 32'h66);

    // hold for three cycles, then release
    set_d(1, 4'd1, 4'd2, 4'd3, 32'hA1, 32'hA2, 32'hA3, C_ALU);
    step();
    hold_e = 1'b1;
    set_d(1, 4'd4, 4'd4, 4'd4, 32'hB1, 32'hB2, 32'hB3, C_USE2R);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", stall_d, 1);
      step();
      check("hold_op1", e_op1, 32'hA1);
      check("hold_imm", e_imm, 32'hA3);
    end
    hold_e = 1'b0;
    #1 check("rel_stall", stall_d, 0);
    step();
    check("rel_op1", e_op1, 32'hB1);
    check("rel_op2", e_op2, 32'hB2);

    // back-to-back self-dependent loads drive the counter into saturation
    set_d(1, 4'd5, 4'd0, 4'd5, 32'h5, 32'h0, 32'h0, C_LOAD);
    repeat (2 * CNT_MAX + 20) step();
    check("sat_cnt", bubble_cnt, CNT_MAX);

    // asynchronous reset between edges while a stall is pending
    step();
    check("pre_rst_stall", stall_d, 1);
    #1 reset = 1'b0;
    #1;
    check("ar_valid", e_valid, 0);
    check("ar_cnt", bubble_cnt, 0);
    check("ar_op1", e_op1, 0);
    check("ar_wa", e_wa, 0);
    check("ar_ctrl", e_ctrl, 0);
    check("ar_stall", stall_d, 0);
    step();
    reset = 1'b1;
    step();
    check("rr_valid", e_valid, 1);
    check("rr_cnt", bubble_cnt, 0);
    #1 check("rr_stall", stall_d, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
